uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

UART transmit engine that drains the AXI-to-UART transmit FIFO (`axi_internal_fifo`, TX instance) and serializes each byte onto the `tx_o` line. It sits between the FIFO's head (`data_o` plus the load status bit) and the UART pad. It issues exactly one `pull_i` per frame. It generates its own bit timing from a programmable clock divisor.

## Interface
- `DATA_SIZE`, default 8: data bits per frame; must match the FIFO `DATA_SIZE`.
- `DIV_WIDTH`, default 16: width of the baud divisor.
- `clk_i`, in, 1: clock.
- `arstn_i`, in, 1: reset, asynchronous, active-low.
- `rst_i`, in, 1: synchronous soft reset, active-high.
- `en_i`, in, 1: transmitter enable.
- `div_i`, in, `DIV_WIDTH`: bit period minus one, in `clk_i` cycles.
- `fifo_load_i`, in, 1: FIFO head entry is valid (FIFO load status bit).
- `fifo_data_i`, in, `DATA_SIZE`: FIFO head data (combinational `data_o`).
- `fifo_pull_o`, out, 1: one-cycle pull strobe to the FIFO `pull_i`.
- `parity_odd_i`, in, 1: parity sense (1 = odd, 0 = even); present only with `UART_TX_PARITY_EN`.
- `tx_o`, out, 1: serial line, idle high.
- `busy_o`, out, 1: a frame is in progress.
- `done_o`, out, 1: one-cycle pulse at the end of the stop bit.

## Operation
- FSM states are IDLE, START, DATA, PARITY (macro only) and STOP.
- **IDLE**
  - `tx_o`=1 and `busy_o`=0.
  - If `en_i` && `fifo_load_i`: assert `fifo_pull_o` for exactly this cycle, capture `fifo_data_i` into a shift register, latch `div_i` into a divisor register, and go to START.
- **START**: `tx_o`=0 for one bit period.
- **DATA**
  - Emits `DATA_SIZE` bits, LSB first, one bit period each.
  - A bit counter runs 0..`DATA_SIZE`-1.
  - The shift register shifts right at each bit boundary.
- **PARITY**: emits XOR of the data bits, inverted when `parity_odd_i`=1, for one bit period.
- **STOP**: `tx_o`=1 for one bit period. On its last cycle, pulse `done_o` and go to IDLE.
- **Bit timer**
  - Counts from 0 to the latched divisor, then reloads.
  - A bit period is `div_i`+1 cycles; `div_i`=0 gives 1 cycle per bit.
  - Arithmetic is unsigned in `DIV_WIDTH` bits, with no overflow path.
- `div_i` changes mid-frame have no effect; the new value is used from the next pull.
- `en_i` deasserted mid-frame: the current frame completes, and no new pull is issued.
- `fifo_load_i` dropping mid-frame has no effect, because data is already captured.
- `fifo_pull_o` is never asserted when `fifo_load_i`=0. At most one pull occurs per frame.

## Timing
- **Reset values** (both `arstn_i` and `rst_i`): `tx_o`=1, `fifo_pull_o`=0, `busy_o`=0, `done_o`=0, state IDLE, all counters 0.
- `rst_i` mid-frame: the next cycle has `tx_o`=1 and IDLE, and the frame is abandoned. A byte already pulled is lost.
- **Pull to start latency**: the start bit (`tx_o`=0) begins on the cycle after `fifo_pull_o`.
- **Frame length**:
  - (2+`DATA_SIZE`)·(`div_i`+1) cycles.
  - Add one extra bit period with parity.
- **Back-to-back frames**: one IDLE cycle between `done_o` and the next `fifo_pull_o`. The gap is 1 clock at `tx_o`=1.
- `busy_o` is 1 from the first START cycle through the last STOP cycle, inclusive.
- All outputs are registered. `tx_o` is glitch-free.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- **Defined**: the PARITY state and the `parity_odd_i` port exist, and the frame is start + data + parity + stop.
- **Undefined**: no PARITY state and no `parity_odd_i` port. The DATA state transitions directly to STOP.

## Structure
- Shared package `uart_pkg`:
  - FSM state typedef `uart_tx_state_t`.
  - `UART_IDLE_LEVEL`=1'b1.
  - `UART_START_LEVEL`=1'b0.
  - `UART_STOP_BITS`=1.
- Sub-module `uart_baud_gen`:
  - Inputs: divisor, clear.
  - Output: `bit_tick` on the last cycle of each bit period.
  - The top block clears it on each pull.
- The top block holds the FSM, shift register, bit counter and parity accumulator.

## Test plan
- **Single frame.** `div_i`=3, FIFO holds 0x55, `en_i`=1.
  - One `fifo_pull_o` pulse.
  - `tx_o` shows 0,1,0,1,0,1,0,1,0,1, with each level held 4 cycles.
  - `done_o` pulses at cycle 40 after the pull.
- **Back-to-back frames.** `div_i`=0, FIFO holds 0xA3 and 0x0F.
  - Two pulls.
  - Frames of 10 cycles each, separated by exactly 1 idle cycle.
  - Bits are LSB-first.
- **Parity** (`UART_TX_PARITY_EN`). `div_i`=1, byte 0x07.
  - `parity_odd_i`=1: parity bit=0.
  - `parity_odd_i`=0: parity bit=1.
  - Frame is 22 cycles.
- **Empty FIFO and enable.**
  - `fifo_load_i`=0 for 50 cycles: no pull, `tx_o`=1, `busy_o`=0.
  - `en_i` dropped during DATA: the frame completes, then no further pull.
- **Reset mid-frame.**
  - `rst_i` asserted during bit 3 of 0x00: next cycle `tx_o`=1, `busy_o`=0, IDLE.
  - `arstn_i` low during STOP: `tx_o`=1 asynchronously, and there is no `done_o`.
- **Divisor change mid-frame.** `div_i` changed from 2 to 5 during DATA: the current frame keeps 3-cycle bits, and the next frame uses 6-cycle bits.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: line levels, stop-bit count and the transmit FSM encoding.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
package uart_pkg;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;
    localparam int   UART_STOP_BITS   = 1;

    // Plain vector encoding so existing code that compares raw state values keeps working.
    typedef logic [2:0] uart_tx_state_t;

    localparam uart_tx_state_t ST_IDLE   = 3'd0;
    localparam uart_tx_state_t ST_START  = 3'd1;
    localparam uart_tx_state_t ST_DATA   = 3'd2;
    localparam uart_tx_state_t ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam uart_tx_state_t ST_PARITY = 3'd4;
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..div, flags the last cycle of each bit period and
// also provides a one-cycle look-ahead of that flag for registered outputs.
module uart_baud_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 arstn_i,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 bit_tick,
    output logic                 tick_ahead
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_nxt;

    // Next count: wrap at the divisor, restart from zero on clear.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        cnt_nxt = cnt_q + 1'b1;
        if (clear || (cnt_q == div)) begin
            cnt_nxt = '0;
        end
    end

    assign bit_tick   = !clear && (cnt_q == div);
    assign tick_ahead = (cnt_nxt == div);

    // Counter register.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            cnt_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            cnt_q <= cnt_nxt;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: pulls one byte per frame from the TX FIFO head and
// serializes start, data (LSB first), optional parity and stop bits onto tx_o.
// Optional feature macro: UART_TX_PARITY_EN (parity bit and parity_odd_i port).
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 arstn_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 fifo_load_i,
    input  logic [DATA_SIZE-1:0] fifo_data_i,
    output logic                 fifo_pull_o,
`ifdef UART_TX_PARITY_EN
    input  logic                 parity_odd_i,
`endif
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int CNT_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_SIZE - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(UART_STOP_BITS - 1);

    uart_tx_state_t       state_q,   state_nxt;
    logic [DATA_SIZE-1:0] shift_q,   shift_nxt;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_nxt;
    logic [DIV_WIDTH-1:0] div_q,     div_nxt;
    logic                 tx_q,      tx_nxt;
    logic                 busy_q,    busy_nxt;
    logic                 done_q,    done_nxt;
    logic                 pull_q,    pull_nxt;
`ifdef UART_TX_PARITY_EN
    logic                 par_q,     par_nxt;
`endif

    logic bit_tick;
    logic tick_ahead;

    // The timer restarts on every pull so the start bit gets a full period.
    uart_baud_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_gen (
        .clk_i      (clk_i),
        .arstn_i    (arstn_i),
        .clear      (pull_q | rst_i),
        .div        (div_q),
        .bit_tick   (bit_tick),
        .tick_ahead (tick_ahead)
    );

    // Frame sequencing; outputs are computed one cycle ahead so they can be registered.
    always_comb begin
        state_nxt   = state_q;
        shift_nxt   = shift_q;
        bit_cnt_nxt = bit_cnt_q;
        div_nxt     = div_q;
        tx_nxt      = tx_q;
        busy_nxt    = busy_q;
        pull_nxt    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_nxt     = par_q;
`endif

        case (state_q)
            ST_IDLE: begin
                tx_nxt   = UART_IDLE_LEVEL;
                busy_nxt = 1'b0;
                if (en_i && fifo_load_i) begin
                    pull_nxt    = 1'b1;
                    shift_nxt   = fifo_data_i;
                    div_nxt     = div_i;
                    bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
                    par_nxt     = 1'b0;
`endif
                    state_nxt   = ST_START;
                end
            end
            ST_START: begin
                // The pull cycle sits in START with the line still idle; the start bit follows.
                if (pull_q) begin
                    tx_nxt   = UART_START_LEVEL;
                    busy_nxt = 1'b1;
                end else if (bit_tick) begin
                    tx_nxt    = shift_q[0];
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
`ifdef UART_TX_PARITY_EN
                    par_nxt = par_q ^ shift_q[0];
`endif
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        tx_nxt    = par_q ^ shift_q[0] ^ parity_odd_i;
                        state_nxt = ST_PARITY;
`else
                        tx_nxt    = UART_IDLE_LEVEL;
                        state_nxt = ST_STOP;
`endif
                    end else begin
                        bit_cnt_nxt = bit_cnt_q + 1'b1;
                        shift_nxt   = shift_q >> 1;
                        tx_nxt      = shift_nxt[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) begin
                    tx_nxt    = UART_IDLE_LEVEL;
                    state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        bit_cnt_nxt = '0;
                        busy_nxt    = 1'b0;
                        tx_nxt      = UART_IDLE_LEVEL;
                        state_nxt   = ST_IDLE;
                    end else begin
                        bit_cnt_nxt = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_nxt    = UART_IDLE_LEVEL;
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase

        // done_o must be high during the last stop cycle, so it is predicted here.
        done_nxt = (state_nxt == ST_STOP) && (bit_cnt_nxt == LAST_STOP) && tick_ahead;

        // Soft reset abandons the frame; a byte already pulled is dropped.
        if (rst_i) begin
            state_nxt   = ST_IDLE;
            shift_nxt   = '0;
            bit_cnt_nxt = '0;
            div_nxt     = '0;
            tx_nxt      = UART_IDLE_LEVEL;
            busy_nxt    = 1'b0;
            done_nxt    = 1'b0;
            pull_nxt    = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_nxt     = 1'b0;
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            div_q     <= '0;
            tx_q      <= UART_IDLE_LEVEL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pull_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_nxt;
            shift_q   <= shift_nxt;
            bit_cnt_q <= bit_cnt_nxt;
            div_q     <= div_nxt;
            tx_q      <= tx_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            pull_q    <= pull_nxt;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_nxt;
`endif
        end
    end

    assign tx_o        = tx_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign fifo_pull_o = pull_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: a FIFO model feeds bytes, every byte
// pushed is also queued as an expected frame, and a frame receiver checks each frame.
module tb_uart_tx_serializer;

    logic        clk_i = 1'b0;
    logic        arstn_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        en_i = 1'b0;
    logic [15:0] div_i = '0;
    logic        fifo_load_i = 1'b0;
    logic [7:0]  fifo_data_i = '0;
    logic        fifo_pull_o;
    logic        par_odd_tb = 1'b0;
    logic        tx_o;
    logic        busy_o;
    logic        done_o;

    int errors = 0;
    int checks = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    uart_tx_serializer #(
        .DATA_SIZE (8),
        .DIV_WIDTH (16)
    ) dut (
        .clk_i        (clk_i),
        .arstn_i      (arstn_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .div_i        (div_i),
        .fifo_load_i  (fifo_load_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_pull_o  (fifo_pull_o),
`ifdef UART_TX_PARITY_EN
        .parity_odd_i (par_odd_tb),
`endif
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    // FIFO model: pop on an observed pull, then present the new head.
    always @(negedge clk_i) begin
        if (fifo_pull_o === 1'b1 && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
        end
        fifo_load_i = (fifo_q.size() > 0);
        fifo_data_i = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic wait_pull(input int max_wait, input string name, output bit ok);
        int n = 0;
        ok = 1'b1;
        while (fifo_pull_o !== 1'b1) begin
            if (n == max_wait) begin
                checks++;
                errors++;
                $display("FAIL %s pull: no pull within %0d cycles (required one)", name, max_wait);
                ok = 1'b0;
                return;
            end
            @(negedge clk_i);
            n++;
        end
    endtask

    // Receives one frame starting from the pull cycle. act_kind 1 drops en_i and
    // act_kind 2 loads new_div into div_i at the start of bit act_bit.
    task automatic rx_frame(input int div, input int max_wait, input int act_bit,
                            input int act_kind, input int new_div, input string name);
        bit ok;
        logic [7:0] exp;
        logic [7:0] got;
        logic exp_lvl;
        bit last;
        int nbits;
        int lvl_bad = 0;
        int busy_bad = 0;
        int done_bad = 0;
        nbits = 10 + PB;
        got = '0;
        wait_pull(max_wait, name, ok);
        if (!ok) return;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: pull with no byte expected", name);
            return;
        end
        exp = exp_q.pop_front();
        if (tx_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL %s pull_cycle: tx=%b busy=%b done=%b required 1 0 0", name, tx_o, busy_o, done_o);
        end
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c <= div; c++) begin
                @(negedge clk_i);
                if (b == 0) exp_lvl = 1'b0;
                else if (b <= 8) exp_lvl = exp[b-1];
                else if (b == nbits - 1) exp_lvl = 1'b1;
                else exp_lvl = (^exp) ^ par_odd_tb;
                last = (b == nbits - 1) && (c == div);
                if (tx_o !== exp_lvl) lvl_bad++;
                if (busy_o !== 1'b1 || fifo_pull_o !== 1'b0) busy_bad++;
                if (done_o !== last) done_bad++;
                if (c == 0 && b >= 1 && b <= 8) got[b-1] = tx_o;
                if (b == act_bit && c == 0) begin
                    if (act_kind == 1) en_i = 1'b0;
                    if (act_kind == 2) div_i = 16'(new_div);
                end
            end
        end
        checks++;
        if (lvl_bad != 0) begin
            errors++;
            $display("FAIL %s tx_level: %0d cycles wrong, required 0", name, lvl_bad);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL %s busy_nopull: %0d cycles wrong, required 0", name, busy_bad);
        end
        checks++;
        if (done_bad != 0) begin
            errors++;
            $display("FAIL %s done_pulse: %0d cycles wrong, required 0", name, done_bad);
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s byte: got %h required %h", name, got, exp);
        end
        @(negedge clk_i);
        checks++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: tx=%b busy=%b done=%b required 1 0 0", name, tx_o, busy_o, done_o);
        end
    endtask

    task automatic test_reset();
        arstn_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || fifo_pull_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: tx=%b busy=%b done=%b pull=%b required 1 0 0 0",
                     tx_o, busy_o, done_o, fifo_pull_o);
        end
        arstn_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_single_frame();
        div_i = 16'd3;
        en_i  = 1'b1;
        push_byte(8'h55);
        rx_frame(3, 20, -1, 0, 0, "single_55");
    endtask

    task automatic test_back_to_back();
        div_i = 16'd0;
        push_byte(8'hA3);
        push_byte(8'h0F);
        rx_frame(0, 20, -1, 0, 0, "b2b_first");
        rx_frame(0, 1, -1, 0, 0, "b2b_second");
    endtask

    task automatic test_parity();
        div_i = 16'd1;
        par_odd_tb = 1'b1;
        push_byte(8'h07);
        rx_frame(1, 20, -1, 0, 0, "parity_odd");
        par_odd_tb = 1'b0;
        push_byte(8'h07);
        rx_frame(1, 20, -1, 0, 0, "parity_even");
    endtask

    task automatic test_empty_fifo();
        int bad = 0;
        en_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (fifo_pull_o !== 1'b0 || tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL empty_fifo: %0d cycles not idle, required 0", bad);
        end
    endtask

    task automatic test_enable_drop();
        int bad = 0;
        div_i = 16'd1;
        en_i  = 1'b1;
        push_byte(8'h12);
        push_byte(8'h34);
        rx_frame(1, 20, 4, 1, 0, "en_drop");
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            if (fifo_pull_o !== 1'b0 || busy_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL en_drop_nopull: %0d cycles active, required 0", bad);
        end
        fifo_q.delete();
        exp_q.delete();
        @(negedge clk_i);
        en_i = 1'b1;
    endtask

    task automatic test_soft_reset();
        bit ok;
        div_i = 16'd3;
        push_byte(8'h00);
        wait_pull(20, "soft_rst", ok);
        if (!ok) return;
        void'(exp_q.pop_front());
        // Cycle P+18 lies inside data bit 3 (cycles P+17..P+20).
        repeat (18) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || fifo_pull_o !== 1'b0) begin
            errors++;
            $display("FAIL soft_rst_state: tx=%b busy=%b done=%b pull=%b required 1 0 0 0",
                     tx_o, busy_o, done_o, fifo_pull_o);
        end
        rst_i = 1'b0;
        push_byte(8'h5A);
        rx_frame(3, 20, -1, 0, 0, "after_soft_rst");
    endtask

    task automatic test_async_reset();
        bit ok;
        int bad = 0;
        div_i = 16'd3;
        push_byte(8'h81);
        wait_pull(20, "async_rst", ok);
        if (!ok) return;
        void'(exp_q.pop_front());
        // Stop bit occupies P+37..P+40; reset lands at P+38.
        repeat (38) @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL async_rst_pre: busy=%b required 1", busy_o);
        end
        arstn_i = 1'b0;
        #1;
        checks++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_now: tx=%b busy=%b required 1 0", tx_o, busy_o);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (done_o !== 1'b0) bad++;
        end
        arstn_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (done_o !== 1'b0 || busy_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL async_rst_nodone: %0d cycles with done/busy, required 0", bad);
        end
    endtask

    task automatic test_div_change();
        div_i = 16'd2;
        push_byte(8'h3C);
        push_byte(8'hC5);
        rx_frame(2, 20, 4, 2, 5, "div_old");
        rx_frame(5, 1, -1, 0, 0, "div_new");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_empty_fifo();
        test_enable_drop();
        test_soft_reset();
        test_async_reset();
        test_div_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so a stuck run still ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation limit reached");
        $fatal(1, "timeout");
    end

endmodule
